// File: rtl/vend_pkg.sv
// vend_pkg: coin encodings, coin values and FSM states shared by the credit stage
package vend_pkg;
  typedef enum logic [1:0] {
    COIN_NICKEL  = 2'd0,
    COIN_DIME    = 2'd1,
    COIN_QUARTER = 2'd2,
    COIN_DOLLAR  = 2'd3
  } coin_e;
  localparam int unsigned VAL_NICKEL  = 5;
  localparam int unsigned VAL_DIME    = 10;
  localparam int unsigned VAL_QUARTER = 25;
  localparam int unsigned VAL_DOLLAR  = 100;
  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_e;
  function automatic int unsigned coin_value(input logic [1:0] t);
    return t == COIN_NICKEL  ? VAL_NICKEL  :
           t == COIN_DIME    ? VAL_DIME    :
           t == COIN_QUARTER ? VAL_QUARTER : VAL_DOLLAR;
  endfunction
endpackage

// File: rtl/vend_credit_accum_credit_adder.sv
// credit_adder: W-bit ripple-carry adder built from full-adder cells (a, b, cin -> sum, cout)
module credit_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[W];
endmodule

// File: rtl/vend_credit_accum.sv
// vend_credit_accum: coin credit accumulator with vend/cancel decision and change handshake
//   in : clk, rst, coin_valid, coin_type, select, cancel, change_ack
//   out: credit, coin_reject, insufficient, dispense, change_valid, change_amount, busy
module vend_credit_accum
  import vend_pkg::*;
#(
  parameter int CREDIT_W   = 8,
  parameter int PRICE      = 75,
  parameter int MAX_CREDIT = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                select,
  input  logic                cancel,
  input  logic                change_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                insufficient,
  output logic                dispense,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  output logic                busy
);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] MAX_C   = CREDIT_W'(MAX_CREDIT);
  state_e state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, amt_q, amt_d, sum;
  logic rej_q, rej_d, ins_q, ins_d, disp_q, disp_d, cv_q, cv_d, busy_q, busy_d, cout, fits;
  credit_adder #(.W(CREDIT_W)) u_add (
    .a   (credit_q),
    .b   (CREDIT_W'(coin_value(coin_type))),
    .cin (1'b0),
    .sum (sum),
    .cout(cout)
  );
  // a carry out means the true sum already exceeds any representable credit
  assign fits = !cout && sum <= MAX_C;
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    amt_d    = amt_q;
    cv_d     = cv_q;
    rej_d    = 1'b0;
    ins_d    = 1'b0;
    disp_d   = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (cancel) begin
          if (state_q == COLLECT) begin
            amt_d    = credit_q;
            credit_d = '0;
            cv_d     = 1'b1;
            state_d  = CHANGE;
          end
        end else if (coin_valid) begin
          credit_d = fits ? sum : credit_q;
          state_d  = fits ? COLLECT : state_q;
          rej_d    = !fits;
        end else if (select) begin
          if (state_q == COLLECT && credit_q >= PRICE_C) begin
            // dispense and the remaining change become visible during the VEND cycle
            state_d  = VEND;
            disp_d   = 1'b1;
            amt_d    = credit_q - PRICE_C;
            credit_d = '0;
          end else begin
            ins_d = 1'b1;
          end
        end
      end
      VEND: begin
        rej_d   = coin_valid;
        cv_d    = amt_q != '0;
        state_d = cv_d ? CHANGE : IDLE;
      end
      CHANGE: begin
        rej_d   = coin_valid;
        cv_d    = !change_ack;
        amt_d   = change_ack ? '0 : amt_q;
        state_d = change_ack ? IDLE : CHANGE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d == VEND || state_d == CHANGE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      amt_q    <= '0;
      cv_q     <= 1'b0;
      rej_q    <= 1'b0;
      ins_q    <= 1'b0;
      disp_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      amt_q    <= amt_d;
      cv_q     <= cv_d;
      rej_q    <= rej_d;
      ins_q    <= ins_d;
      disp_q   <= disp_d;
      busy_q   <= busy_d;
    end
  end
  assign credit        = credit_q;
  assign coin_reject   = rej_q;
  assign insufficient  = ins_q;
  assign dispense      = disp_q;
  assign change_valid  = cv_q;
  assign change_amount = amt_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_vend_credit_accum.sv
// tb_vend_credit_accum: directed plus random stimulus against a cents-level reference model
module tb_vend_credit_accum;
  localparam int PRICE = 75;
  localparam int MAXC  = 200;
  logic clk = 1'b0, rst = 1'b1;
  logic coin_valid = 1'b0, select = 1'b0, cancel = 1'b0, change_ack = 1'b0;
  logic [1:0] coin_type = 2'd0;
  logic [7:0] credit, change_amount;
  logic coin_reject, insufficient, dispense, change_valid, busy;
  int n_chk = 0, n_fail = 0;
  int coin_val [4] = '{5, 10, 25, 100};
  // reference: phase 0 idle (no credit), 1 holding credit, 2 vending, 3 returning change
  int m_phase = 0, m_credit = 0, m_amt = 0;
  bit m_cv = 0, m_rej = 0, m_ins = 0, m_disp = 0;
  vend_credit_accum dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
    .select(select), .cancel(cancel), .change_ack(change_ack),
    .credit(credit), .coin_reject(coin_reject), .insufficient(insufficient),
    .dispense(dispense), .change_valid(change_valid), .change_amount(change_amount), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model(input bit r, cv, input int ct, input bit sel, can, ack);
    int v;
    m_rej = 0; m_ins = 0; m_disp = 0;
    if (r) begin
      m_phase = 0; m_credit = 0; m_amt = 0; m_cv = 0;
      return;
    end
    v = coin_val[ct];
    if (m_phase == 2) begin
      m_rej = cv;
      m_cv = m_amt != 0;
      m_phase = m_cv ? 3 : 0;
    end else if (m_phase == 3) begin
      m_rej = cv;
      if (ack) begin m_cv = 0; m_amt = 0; m_phase = 0; end
    end else if (can) begin
      if (m_phase == 1) begin m_amt = m_credit; m_credit = 0; m_cv = 1; m_phase = 3; end
    end else if (cv) begin
      if (m_credit + v > MAXC) m_rej = 1;
      else begin m_credit += v; m_phase = 1; end
    end else if (sel) begin
      if (m_phase == 1 && m_credit >= PRICE) begin
        m_disp = 1; m_amt = m_credit - PRICE; m_credit = 0; m_phase = 2;
      end else m_ins = 1;
    end
  endtask
  task automatic step(input bit r, cv, input int ct, input bit sel, can, ack);
    @(negedge clk);
    rst = r; coin_valid = cv; coin_type = 2'(ct); select = sel; cancel = can; change_ack = ack;
    @(posedge clk);
    model(r, cv, ct, sel, can, ack);
    #1;
    chk("credit", int'(credit), m_credit);
    chk("coin_reject", int'(coin_reject), int'(m_rej));
    chk("insufficient", int'(insufficient), int'(m_ins));
    chk("dispense", int'(dispense), int'(m_disp));
    chk("change_valid", int'(change_valid), int'(m_cv));
    chk("change_amount", int'(change_amount), m_amt);
    chk("busy", int'(busy), int'(m_phase >= 2));
  endtask
  task automatic coin(input int ct); step(0, 1, ct, 0, 0, 0); endtask
  task automatic idle(input int k); for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0); endtask
  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    coin(2); coin(2); coin(2);
    step(0, 0, 0, 1, 0, 0);
    idle(2);
    coin(3);
    step(0, 0, 0, 1, 0, 0);
    idle(4);
    step(0, 0, 0, 0, 0, 1);
    idle(1);
    coin(3); coin(3); coin(0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    coin(1);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 2, 0, 1, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 1);
    coin(2); coin(2); coin(2); coin(2);
    step(0, 0, 0, 1, 0, 0);
    coin(1);
    coin(0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    coin(1);
    step(0, 0, 0, 0, 1, 0);
    idle(1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 800; i++)
      step($urandom_range(99) == 0, $urandom_range(99) < 40, int'($urandom_range(3)),
           $urandom_range(99) < 20, $urandom_range(99) < 8, $urandom_range(99) < 30);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vend_credit_accum.md
Name: vend_credit_accum

Overview:
- Sequential coin-credit stage of the vending machine; consumes the full-adder datapath to accumulate inserted coin values into a credit register.
- Decides vend/cancel and produces a one-cycle dispense strobe plus a change amount under a valid/ack handshake.
- Sits between the coin sensor decoder (upstream) and the dispense/change driver (downstream).

Parameters:
- CREDIT_W, 8, width in bits of credit, adder and change_amount.
- PRICE, 75, item price in cents; must be greater than 0 and no greater than MAX_CREDIT.
- MAX_CREDIT, 200, highest credit accepted; any coin that would exceed it is rejected.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- coin_valid  in  1  one-cycle strobe; a coin is present.
- coin_type  in  2  coin code: 0 = nickel (5), 1 = dime (10), 2 = quarter (25), 3 = dollar (100).
- select  in  1  one-cycle strobe; user requests the item.
- cancel  in  1  one-cycle strobe; user requests a refund.
- change_ack  in  1  downstream has taken change_amount.
- credit  out  CREDIT_W  current accumulated credit.
- coin_reject  out  1  one-cycle pulse; the coin was not credited.
- insufficient  out  1  one-cycle pulse; select arrived with credit below PRICE.
- dispense  out  1  one-cycle pulse; release the item.
- change_valid  out  1  change_amount is valid; held until change_ack.
- change_amount  out  CREDIT_W  cents to return.
- busy  out  1  high in VEND or CHANGE.

Behaviour:
- Reset, synchronous on the clk edge with rst=1: state IDLE, credit=0, change_amount=0, and every pulse output, change_valid and busy at 0. Reset overrides any in-flight operation, including CHANGE with an un-acked change.
- States are IDLE, COLLECT, VEND and CHANGE. All outputs are registered.
- Coin handling in IDLE or COLLECT:
  - sum = credit + coin value, computed by the adder with carry-out.
  - If carry-out=1 or sum > MAX_CREDIT: credit is unchanged and coin_reject=1 on the next cycle.
  - Otherwise credit=sum on the next edge (1-cycle latency) and the state goes to COLLECT.
- Input priority in a single cycle: cancel > coin_valid > select. Lower-priority strobes in the same cycle are dropped silently, with no pulse. The only exception is that a coin arriving in VEND or CHANGE is rejected.
- cancel:
  - In COLLECT: change_amount=credit, credit=0, go to CHANGE.
  - In IDLE: no effect.
- select:
  - In COLLECT with credit >= PRICE: go to VEND.
  - In COLLECT with credit < PRICE: insufficient=1 for one cycle and the state stays COLLECT.
  - In IDLE: insufficient=1 for one cycle.
- VEND, exactly one cycle:
  - dispense=1, change_amount = credit - PRICE (never negative, guaranteed by the entry condition), credit=0.
  - Next state is IDLE if change_amount=0, else CHANGE.
- CHANGE:
  - change_valid=1 and change_amount held stable until change_ack=1 is sampled.
  - The cycle after that: change_valid=0, change_amount=0, state IDLE.
  - change_ack outside CHANGE is ignored.
- Any coin_valid in VEND or CHANGE: coin_reject=1 on the next cycle, with no credit change.
- busy is 1 in VEND and in CHANGE.
- Credit never exceeds MAX_CREDIT. The comparisons use unsigned CREDIT_W-bit arithmetic.

Decomposition:
- The shared package vend_pkg holds:
  - the coin_type encodings;
  - the coin value constants (5, 10, 25, 100);
  - the state enum typedef (IDLE, COLLECT, VEND, CHANGE).
- Sub-module credit_adder: a CREDIT_W-bit ripple-carry adder chained from full-adder cells. Inputs a, b and cin (tied 0); outputs sum and cout.
- The subtraction for change is done in the top level.

Test Plan:
- Reset with rst=1 for 2 cycles mid-CHANGE (change_valid=1) -> next cycle credit=0, change_valid=0, busy=0, state IDLE.
- Coins quarter, quarter, quarter, then select -> credit 25/50/75, dispense=1 for one cycle, change_amount=0, back to IDLE, change_valid never asserted.
- Dollar then select -> dispense=1, then change_valid=1 with change_amount=25, held for 3 cycles without ack; assert change_ack -> change_valid=0 next cycle, IDLE.
- Dollar, dollar (credit=200), then nickel -> coin_reject=1 on the next cycle, credit stays 200.
- Dime then select -> insufficient=1 for one cycle, credit=10. Then cancel together with coin_valid (quarter) -> CHANGE with change_amount=10, and the quarter is neither credited nor flagged.
- Coin inserted during VEND and during CHANGE -> coin_reject=1 each time, change_amount unchanged.
